// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader shared constants.
// State encoding and frame header length.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int HDR_LEN = 2;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs bytes MSB-first into a 32-bit word.
// Ports: clk, rst (async low), clr, en, din -> word, idx, full, xsum.
module imem_boot_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic        full,
  output logic [7:0]  xsum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
      xsum <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
      xsum <= '0;
    end else if (en) begin
      word <= {word[23:0], din};
      idx  <= idx + 2'd1;
      xsum <= xsum ^ din;
    end
  end

  // Next shifted byte completes the word.
  assign full = (idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader into instruction BRAM.
// Ports: clk, rst, start, rx_* stream, imem_* write, core_hold, done, error, word_count.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [15:0] MAXN = 16'(MAX_WORDS);

  state_t      state, state_d;
  logic [15:0] n;
  logic [15:0] wc;
  logic        hs;
  logic        clr;
  logic        full;
  logic [1:0]  idx;
  logic [7:0]  xsum;
  logic [15:0] len;
  logic        len_bad;

  assign hs      = rx_valid & rx_ready;
  assign len     = {n[15:8], rx_data};
  assign len_bad = (len == 16'd0) || (len > MAXN);

  imem_boot_loader_word_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (hs && state == DATA),
    .din  (rx_data),
    .word (imem_wdata),
    .idx  (idx),
    .full (full),
    .xsum (xsum)
  );

  always_comb begin
    state_d = state;
    clr     = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          clr     = 1'b1;
        end
      end
      LEN_HI: if (hs) state_d = LEN_LO;
      LEN_LO: if (hs) state_d = len_bad ? ERR : DATA;
      DATA:   if (hs && full) state_d = WRITE;
      WRITE:  state_d = (wc + 16'd1 < n) ? DATA : CSUM;
      CSUM:   if (hs) state_d = (rx_data == xsum) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      n       <= '0;
      wc      <= '0;
      imem_we <= 1'b0;
    end else begin
      state   <= state_d;
      imem_we <= (state_d == WRITE);
      if (clr)
        wc <= '0;
      else if (state == WRITE)
        wc <= wc + 16'd1;
      if (hs && state == LEN_HI)
        n[15:8] <= rx_data;
      if (hs && state == LEN_LO)
        n[7:0] <= rx_data;
    end
  end

  assign rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                    (state == DATA)   || (state == CSUM);

  // A restart from DONE re-holds the core in the start cycle itself.
  assign done       = (state == DONE) && !start;
  assign core_hold  = !done;
  assign error      = (state == ERR);
  assign word_count = wc;
  assign imem_addr  = wc[ADDR_W-1:0];

  logic unused;
  assign unused = ^idx;

endmodule
